mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/counter_pkg.sv | 17 +
 rtl/mod_counter.sv | 123 ++++++++++++
 tb/tb_mod_counter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared types and constants for the modulo counter.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents: state_t (RUN, HALTED) and the direction encodings for the
// `up` input (DIR_UP, DIR_DOWN).
package counter_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo-MODULUS counter with free-run wrap or one-shot halt.
// Latency: one clock from enabled edge to updated count; all outputs registered.
// Backpressure: none; `en` gates stepping, HALTED holds until reset/clear/load.
//
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   en, up          : count enable, direction (1 = increment, 0 = decrement)
//   one_shot        : 1 = halt at terminal value, 0 = wrap around
//   clear, load     : synchronous re-arm to RESET_VALUE / to load_value (clamped)
//   load_value      : value for load
//   count           : registered count, always < MODULUS
//   wrap            : one-cycle pulse after a wrap or terminal hit
//   halted          : high while in HALTED
//   load_err        : one-cycle pulse after a load that had to be clamped
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter longint unsigned  MODULUS     = 256,
  parameter longint unsigned  RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             one_shot,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             halted,
  output logic             load_err
);

  // Parameter legality is enforced at elaboration.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "mod_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "mod_counter: MODULUS must be 2..2**WIDTH");
  end
  if (RESET_VALUE >= MODULUS) begin : g_bad_reset_value
    $fatal(1, "mod_counter: RESET_VALUE must be < MODULUS");
  end

  // All arithmetic is done one bit wider so MODULUS-1 and count+1 never
  // overflow, even when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   TERM_HI = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   step_val;
  logic             at_term;
  logic             load_over;

  // State register (carries all registered outputs as well).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      count_q    <= RST_VAL;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Next-state: clear > load > step. Terminal value depends on the
  // direction sampled this cycle, so a direction change never skips a value.
  always_comb begin
    count_ext  = {1'b0, count_q};
    load_ext   = {1'b0, load_value};
    load_over  = (load_ext > TERM_HI);
    at_term    = (up == DIR_UP) ? (count_ext == TERM_HI) : (count_ext == '0);
    if (up == DIR_UP) begin
      step_val = at_term ? '0 : count_ext + 1'b1;
    end else begin
      step_val = at_term ? TERM_HI : count_ext - 1'b1;
    end

    state_d    = state_q;
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;

    if (clear) begin
      state_d = RUN;
      count_d = RST_VAL;
    end else if (load) begin
      state_d    = RUN;
      count_d    = load_over ? TERM_HI[WIDTH-1:0] : load_value;
      load_err_d = load_over;
    end else if (state_q == RUN && en) begin
      if (at_term && one_shot) begin
        // Step refused at the terminal value: hold and halt.
        state_d = HALTED;
        wrap_d  = 1'b1;
      end else begin
        count_d = step_val[WIDTH-1:0];
        wrap_d  = at_term;
      end
    end
  end

  // Outputs: straight from registers, no input-to-output path.
  always_comb begin
    count    = count_q;
    wrap     = wrap_q;
    halted   = (state_q == HALTED);
    load_err = load_err_q;
  end

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed self-checking bench for mod_counter (WIDTH=8, MODULUS=10).
// Inputs change #1 after a rising edge; outputs are checked #1 after the next edge.
// Each check is an immediate assertion that counts and reports failures.
module tb_mod_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset, en, up, one_shot, clear, load;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       wrap, halted, load_err;

  int checks = 0;
  int errors = 0;

  mod_counter #(.WIDTH(8), .MODULUS(10), .RESET_VALUE(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up         (up),
    .one_shot   (one_shot),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .wrap       (wrap),
    .halted     (halted),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Full output check: count, wrap, halted, load_err.
  task automatic check_all(input string tag, input int c, input int w, input int h, input int le);
    check({tag, ".count"},    int'(count),    c);
    check({tag, ".wrap"},     int'(wrap),     w);
    check({tag, ".halted"},   int'(halted),   h);
    check({tag, ".load_err"}, int'(load_err), le);
  endtask

  int up_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    reset = 1'b1; en = 1'b0; up = DIR_UP; one_shot = 1'b0;
    clear = 1'b0; load = 1'b0; load_value = 8'd0;

    // Reset state
    tick();
    check_all("reset", 0, 0, 0, 0);
    reset = 1'b0;

    // Free-run up: 1..9,0,1,2 with wrap only after 9->0
    en = 1'b1; up = DIR_UP; one_shot = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("up_run[%0d].count", i), int'(count), up_seq[i]);
      check($sformatf("up_run[%0d].wrap", i), int'(wrap), (i == 9) ? 1 : 0);
    end

    // en=0 holds
    en = 1'b0;
    tick();
    check_all("hold_en0", 2, 0, 0, 0);
    tick();
    check_all("hold_en0_b", 2, 0, 0, 0);

    // Down from 0: 9 with wrap, then 8
    reset = 1'b1;
    tick();
    reset = 1'b0; en = 1'b1; up = DIR_DOWN;
    tick();
    check_all("down_wrap", 9, 1, 0, 0);
    tick();
    check_all("down_8", 8, 0, 0, 0);

    // One-shot: load 7, then 8, 9, halt with single wrap pulse
    en = 1'b0; load = 1'b1; load_value = 8'd7;
    tick();
    check_all("load7", 7, 0, 0, 0);
    load = 1'b0; en = 1'b1; up = DIR_UP; one_shot = 1'b1;
    tick();
    check_all("os_8", 8, 0, 0, 0);
    tick();
    check_all("os_9", 9, 0, 0, 0);
    tick();
    check_all("os_halt", 9, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) up = DIR_DOWN;   // direction change must not move a halted counter
      if (i == 3) one_shot = 1'b0;
      tick();
      check_all($sformatf("halted_hold[%0d]", i), 9, 0, 1, 0);
    end

    // Clamped load re-arms and pulses load_err once
    en = 1'b0; one_shot = 1'b0; up = DIR_UP;
    load = 1'b1; load_value = 8'd15;
    tick();
    check_all("load15_clamp", 9, 0, 0, 1);
    load_value = 8'd3;
    tick();
    check_all("load3", 3, 0, 0, 0);
    load = 1'b0;
    tick();
    check_all("after_load", 3, 0, 0, 0);

    // clear beats load on the same edge
    load = 1'b1; load_value = 8'd5;
    tick();
    check("load5.count", int'(count), 5);
    clear = 1'b1; load_value = 8'd15;
    tick();
    check_all("clear_vs_load", 0, 0, 0, 0);
    clear = 1'b0;

    // Drive into HALTED, then reset overrides load and en
    load_value = 8'd8;
    tick();
    load = 1'b0; en = 1'b1; one_shot = 1'b1;
    tick();
    check("pre_halt.count", int'(count), 9);
    tick();
    check_all("pre_halt", 9, 1, 1, 0);
    reset = 1'b1; load = 1'b1; load_value = 8'd5; en = 1'b1;
    tick();
    check_all("reset_override", 0, 0, 0, 0);
    reset = 1'b0; load = 1'b0; one_shot = 1'b0;

    // Up to 4, reverse: 3, 2 with no skipped or repeated value
    up = DIR_UP;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("rev_up[%0d]", i), int'(count), i);
    end
    up = DIR_DOWN;
    tick();
    check_all("rev_3", 3, 0, 0, 0);
    tick();
    check_all("rev_2", 2, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mod_counter
